// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_pkg
//  Description : Shared types for the core datapath. Holds the ALU operand
//                selects, the writeback select, the load/store opcode set,
//                the load/store FSM state encoding and a small opcode decoder.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    localparam int MEM_MASK_W = 8;

    typedef enum logic [1:0] {ALU_A_RS1, ALU_A_PC, ALU_A_ZERO} alu_a_sel_enum;
    typedef enum logic [1:0] {ALU_B_RS2, ALU_B_IMM, ALU_B_FOUR} alu_b_sel_enum;
    typedef enum logic [1:0] {WB_SEL_ALU, WB_SEL_MEM, WB_SEL_PC4, WB_SEL_CSR} wb_sel_op_enum;

    typedef enum logic [3:0] {
        MEM_LB, MEM_LH, MEM_LW, MEM_LD, MEM_LBU, MEM_LHU, MEM_LWU,
        MEM_SB, MEM_SH, MEM_SW, MEM_SD
    } mem_op_enum;

    typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_RESP, MEM_DONE} mem_state_enum;

    typedef enum logic [1:0] {MEM_SZ_B, MEM_SZ_H, MEM_SZ_W, MEM_SZ_D} mem_size_enum;

    typedef struct packed {
        mem_size_enum size;
        logic         sign_ext;
        logic         store;
    } mem_op_info_t;

    // Encodings outside the enum fall through to the LD decode.
    function automatic mem_op_info_t mem_op_decode(input mem_op_enum op);
        mem_op_info_t info;
        info = '{size: MEM_SZ_D, sign_ext: 1'b0, store: 1'b0};
        case (op)
            MEM_LB:  info = '{size: MEM_SZ_B, sign_ext: 1'b1, store: 1'b0};
            MEM_LH:  info = '{size: MEM_SZ_H, sign_ext: 1'b1, store: 1'b0};
            MEM_LW:  info = '{size: MEM_SZ_W, sign_ext: 1'b1, store: 1'b0};
            MEM_LBU: info = '{size: MEM_SZ_B, sign_ext: 1'b0, store: 1'b0};
            MEM_LHU: info = '{size: MEM_SZ_H, sign_ext: 1'b0, store: 1'b0};
            MEM_LWU: info = '{size: MEM_SZ_W, sign_ext: 1'b0, store: 1'b0};
            MEM_SB:  info = '{size: MEM_SZ_B, sign_ext: 1'b0, store: 1'b1};
            MEM_SH:  info = '{size: MEM_SZ_H, sign_ext: 1'b0, store: 1'b1};
            MEM_SW:  info = '{size: MEM_SZ_W, sign_ext: 1'b0, store: 1'b1};
            MEM_SD:  info = '{size: MEM_SZ_D, sign_ext: 1'b0, store: 1'b1};
            default: info = '{size: MEM_SZ_D, sign_ext: 1'b0, store: 1'b0};
        endcase
        return info;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_data_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_data_align
//  Description : Combinational lane logic for the load/store engine: byte
//                mask and lane shift for stores, lane extraction and sign/zero
//                extension for loads, and (optionally) misalignment detection.
//  Ports       : op, addr_lo, store_data, load_raw  -> inputs
//                is_store, wmask, wdata, ldata      -> outputs
//                misalign                           -> output, only with
//                                                      MEM_MISALIGN_TRAP_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_data_align
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  mem_op_enum            op,
    input  logic [2:0]            addr_lo,
    input  logic [XLEN-1:0]       store_data,
    input  logic [XLEN-1:0]       load_raw,
    output logic                  is_store,
    output logic [MEM_MASK_W-1:0] wmask,
    output logic [XLEN-1:0]       wdata,
    output logic [XLEN-1:0]       ldata
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign
`endif
);

    mem_op_info_t          w_info;
    logic [2:0]            w_off;
    logic [MEM_MASK_W-1:0] w_base;
    logic [XLEN-1:0]       w_raw;

    assign w_info = mem_op_decode(op);

    // Misaligned low bits are dropped so the access lands on the naturally
    // aligned unit that contains the address.
    always_comb begin
        w_off  = 3'b000;
        w_base = 8'hFF;
        case (w_info.size)
            MEM_SZ_B: begin w_off = addr_lo;                w_base = 8'h01; end
            MEM_SZ_H: begin w_off = {addr_lo[2:1], 1'b0};   w_base = 8'h03; end
            MEM_SZ_W: begin w_off = {addr_lo[2], 2'b00};    w_base = 8'h0F; end
            default:  begin w_off = 3'b000;                 w_base = 8'hFF; end
        endcase
    end

    assign is_store = w_info.store;
    assign wmask    = w_info.store ? (w_base << w_off) : '0;
    assign wdata    = store_data << {w_off, 3'b000};
    assign w_raw    = load_raw >> {w_off, 3'b000};

    always_comb begin
        ldata = w_raw;
        case (w_info.size)
            MEM_SZ_B: ldata = {{(XLEN-8){w_info.sign_ext & w_raw[7]}},   w_raw[7:0]};
            MEM_SZ_H: ldata = {{(XLEN-16){w_info.sign_ext & w_raw[15]}}, w_raw[15:0]};
            MEM_SZ_W: ldata = {{(XLEN-32){w_info.sign_ext & w_raw[31]}}, w_raw[31:0]};
            default:  ldata = w_raw;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (w_info.size)
            MEM_SZ_H: misalign = addr_lo[0];
            MEM_SZ_W: misalign = |addr_lo[1:0];
            MEM_SZ_D: misalign = |addr_lo;
            default:  misalign = 1'b0;
        endcase
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store engine between the MEM stage and the data bus.
//                Latches one request, issues a valid/ready bus request with
//                byte mask and lane-shifted store data, waits for the bus
//                response and returns extended load data with a done pulse.
//  Ports       : clk, rstn                    - clock, async active-low reset
//                req_valid/op/addr/wdata      - core request
//                stall, done, rdata           - core response
//                mem_req_valid/ready, mem_we, mem_addr, mem_wdata, mem_wmask
//                                             - bus request channel
//                mem_resp_valid, mem_resp_data - bus response channel
//                misalign_err                 - only with MEM_MISALIGN_TRAP_EN
//  Config      : MEM_MISALIGN_TRAP_EN - misaligned accesses complete at once
//                with misalign_err instead of touching the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int MASK_W = XLEN/8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    input  mem_op_enum        req_op,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              stall,
    output logic              done,
    output logic [XLEN-1:0]   rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign_err
`endif
);

    mem_state_enum         r_state;
    mem_op_enum            r_op;
    logic [2:0]            r_addr_lo;

    mem_op_enum            w_op;
    logic [2:0]            w_addr_lo;
    logic                  w_is_store;
    logic [MEM_MASK_W-1:0] w_wmask;
    logic [XLEN-1:0]       w_wdata;
    logic [XLEN-1:0]       w_ldata;
    logic                  w_trap;

    // One lane unit serves both phases: in IDLE it sees the live request so
    // the bus fields can be registered at capture; afterwards it sees the
    // latched copy so the response can be extracted in RESP.
    assign w_op      = (r_state == MEM_IDLE) ? req_op          : r_op;
    assign w_addr_lo = (r_state == MEM_IDLE) ? req_addr[2:0]   : r_addr_lo;

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misalign;
`endif

    mem_data_align #(
        .XLEN       (XLEN)
    ) u_align (
        .op         (w_op),
        .addr_lo    (w_addr_lo),
        .store_data (req_wdata),
        .load_raw   (mem_resp_data),
        .is_store   (w_is_store),
        .wmask      (w_wmask),
        .wdata      (w_wdata),
        .ldata      (w_ldata)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign   (w_misalign)
`endif
    );

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = w_misalign;

    // High only in the DONE cycle that follows a trapped capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= (r_state == MEM_IDLE) && req_valid && w_misalign;
        end
    end
`else
    assign w_trap = 1'b0;
`endif

    // The stall drops in DONE so the core advances on the done pulse.
    assign stall = (r_state != MEM_DONE) && req_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= MEM_IDLE;
            r_op          <= MEM_LB;
            r_addr_lo     <= 3'b000;
            done          <= 1'b0;
            rdata         <= '0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
        end else begin
            case (r_state)
                MEM_IDLE: begin
                    done <= 1'b0;
                    if (req_valid) begin
                        r_op      <= req_op;
                        r_addr_lo <= req_addr[2:0];
                        if (w_trap) begin
                            r_state <= MEM_DONE;
                            done    <= 1'b1;
                            rdata   <= '0;
                        end else begin
                            r_state       <= MEM_REQ;
                            mem_req_valid <= 1'b1;
                            mem_we        <= w_is_store;
                            mem_addr      <= {req_addr[XLEN-1:3], 3'b000};
                            mem_wdata     <= w_wdata;
                            mem_wmask     <= w_wmask;
                        end
                    end
                end
                MEM_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= MEM_RESP;
                    end
                end
                MEM_RESP: begin
                    if (mem_resp_valid) begin
                        rdata   <= w_is_store ? '0 : w_ldata;
                        done    <= 1'b1;
                        r_state <= MEM_DONE;
                    end
                end
                MEM_DONE: begin
                    done    <= 1'b0;
                    r_state <= MEM_IDLE;
                end
                default: begin
                    r_state <= MEM_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit: directed vector
//                table, randomized accesses against a byte-level memory
//                model, back-to-back, reset-abort and misalignment sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    mem_op_enum  req_op;
    logic [63:0] req_addr, req_wdata;
    logic        stall, done;
    logic [63:0] rdata;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    mem_access_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (req_valid),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .stall          (stall),
        .done           (done),
        .rdata          (rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Bus-side memory (written from what the DUT drives) and the model's
    // own expectation of memory contents.
    logic [63:0] busmem [logic [60:0]];
    logic [63:0] shadow [logic [60:0]];

    typedef struct {
        mem_op_enum  op;
        logic [63:0] addr, wdata, resp;
        int          rdy, rsp;
        logic [63:0] eaddr;
        logic        ewe;
        logic [7:0]  emask;
        logic [63:0] ewdata, erdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    // ---------------- reference model (from the access rules) -------------
    function automatic int op_bytes(input mem_op_enum op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: return 1;
            MEM_LH, MEM_LHU, MEM_SH: return 2;
            MEM_LW, MEM_LWU, MEM_SW: return 4;
            default:                 return 8;
        endcase
    endfunction

    function automatic bit op_signed(input mem_op_enum op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW);
    endfunction

    function automatic bit op_store(input mem_op_enum op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW) || (op == MEM_SD);
    endfunction

    function automatic int lane_off(input mem_op_enum op, input logic [63:0] addr);
        int a, n;
        a = int'(addr[2:0]);
        n = op_bytes(op);
        return (a / n) * n;
    endfunction

    function automatic logic [7:0] model_mask(input mem_op_enum op, input logic [63:0] addr);
        int m;
        if (!op_store(op)) return 8'h00;
        m = ((1 << op_bytes(op)) - 1) << lane_off(op, addr);
        return m[7:0];
    endfunction

    function automatic logic [63:0] model_wdata(input mem_op_enum op, input logic [63:0] addr,
                                                input logic [63:0] wd);
        return wd << (8 * lane_off(op, addr));
    endfunction

    function automatic logic [63:0] model_load(input mem_op_enum op, input logic [63:0] addr,
                                               input logic [63:0] dw);
        logic [63:0] v, lim;
        int n;
        n = op_bytes(op);
        v = dw >> (8 * lane_off(op, addr));
        if (n < 8) begin
            lim = 64'd1 << (8 * n);
            v = v % lim;
            if (op_signed(op) && v >= lim / 2) v = v - lim;
        end
        return v;
    endfunction

    // ---------------- one complete access with bus handshake --------------
    task automatic access(input string tag, input mem_op_enum op, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] resp,
                          input int rdy, input int rsp, input bit use_mem,
                          input logic [63:0] eaddr, input logic ewe, input logic [7:0] emask,
                          input logic [63:0] ewdata, input logic [63:0] erdata);
        int n;
        logic [60:0] key;
        logic [63:0] cur;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        #1;
        check({tag, "_c0_stall"}, stall, 1);
        check({tag, "_c0_reqv"}, mem_req_valid, 0);
        check({tag, "_c0_done"}, done, 0);
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!mem_req_valid && n < 16);
        check({tag, "_req_latency"}, n, 1);
        if (!mem_req_valid) begin
            req_valid = 1'b0;
            return;
        end
        for (int i = 0; i <= rdy; i++) begin
            check({tag, "_reqv"}, mem_req_valid, 1);
            check({tag, "_addr"}, mem_addr, eaddr);
            check({tag, "_we"}, mem_we, ewe);
            check({tag, "_mask"}, mem_wmask, emask);
            if (ewe) check({tag, "_wdata"}, mem_wdata, ewdata);
            check({tag, "_stall_req"}, stall, 1);
            if (i < rdy) begin @(negedge clk); #1; end
        end
        mem_req_ready = 1'b1;
        if (use_mem && mem_we) begin
            key = mem_addr[63:3];
            cur = busmem.exists(key) ? busmem[key] : 64'h0;
            for (int b = 0; b < 8; b++)
                if (mem_wmask[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
            busmem[key] = cur;
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        check({tag, "_req_drop"}, mem_req_valid, 0);
        for (int i = 0; i < rsp; i++) begin
            check({tag, "_wait_done"}, done, 0);
            check({tag, "_stall_resp"}, stall, 1);
            @(negedge clk); #1;
        end
        if (use_mem) begin
            key = mem_addr[63:3];
            mem_resp_data = ewe ? {$urandom, $urandom}
                                : (busmem.exists(key) ? busmem[key] : 64'h0);
        end else begin
            mem_resp_data = resp;
        end
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_data  = {$urandom, $urandom};
        #1;
        check({tag, "_done"}, done, 1);
        check({tag, "_stall_done"}, stall, 0);
        check({tag, "_rdata"}, rdata, erdata);
`ifdef MEM_MISALIGN_TRAP_EN
        check({tag, "_noerr"}, misalign_err, 0);
`endif
        req_valid = 1'b0;
    endtask

    // Expectations derived from the shadow memory; shadow updated for stores.
    task automatic model_access(input string tag, input mem_op_enum op, input logic [63:0] addr,
                                input logic [63:0] wdata, input int rdy, input int rsp);
        logic [60:0] key;
        logic [63:0] cur, ewd;
        logic [7:0]  em;
        key = addr[63:3];
        cur = shadow.exists(key) ? shadow[key] : 64'h0;
        em  = model_mask(op, addr);
        ewd = model_wdata(op, addr, wdata);
        access(tag, op, addr, wdata, 64'h0, rdy, rsp, 1'b1, {addr[63:3], 3'b000},
               op_store(op), em, ewd, op_store(op) ? 64'h0 : model_load(op, addr, cur));
        if (op_store(op)) begin
            for (int b = 0; b < 8; b++)
                if (em[b]) cur[8*b +: 8] = ewd[8*b +: 8];
            shadow[key] = cur;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem_op_enum  op;
        logic [63:0] addr, wd, tmp;
        int          n;

        rstn = 1'b1; req_valid = 1'b0; req_op = MEM_LB; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        #2 rstn = 1'b0;
        #1;
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_reqv", mem_req_valid, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_mask", mem_wmask, 0);
        check("rst_stall", stall, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("rst_err", misalign_err, 0);
`endif
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // ---------------- directed vector table ----------------
        vecs.push_back('{MEM_LB,  64'h1003, 64'h0, 64'h0000_0000_80FF_0000, 0, 0,
                         64'h1000, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80});
        vecs.push_back('{MEM_LHU, 64'h2006, 64'h0, 64'hBEEF_0000_0000_0000, 0, 0,
                         64'h2000, 1'b0, 8'h00, 64'h0, 64'h0000_0000_0000_BEEF});
        vecs.push_back('{MEM_SW,  64'h3004, 64'h1234_5678, 64'hFFFF_FFFF_FFFF_FFFF, 4, 1,
                         64'h3000, 1'b1, 8'hF0, 64'h1234_5678_0000_0000, 64'h0});
        vecs.push_back('{MEM_LH,  64'h6002, 64'h0, 64'h1122_3344_8899_AABB, 1, 0,
                         64'h6000, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8899});
        vecs.push_back('{MEM_LW,  64'h6004, 64'h0, 64'h8765_4321_0000_0000, 0, 2,
                         64'h6000, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321});
        vecs.push_back('{MEM_LWU, 64'h6004, 64'h0, 64'h8765_4321_0000_0000, 0, 0,
                         64'h6000, 1'b0, 8'h00, 64'h0, 64'h0000_0000_8765_4321});
        vecs.push_back('{MEM_LBU, 64'h6007, 64'h0, 64'h8765_4321_0000_0000, 0, 0,
                         64'h6000, 1'b0, 8'h00, 64'h0, 64'h0000_0000_0000_0087});
        vecs.push_back('{MEM_LD,  64'h6008, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 2, 1,
                         64'h6008, 1'b0, 8'h00, 64'h0, 64'hDEAD_BEEF_CAFE_F00D});
        vecs.push_back('{MEM_SB,  64'h7005, 64'hAB, 64'h0, 0, 0,
                         64'h7000, 1'b1, 8'h20, 64'h0000_AB00_0000_0000, 64'h0});
        vecs.push_back('{MEM_SH,  64'h7006, 64'hCDEF, 64'h0, 1, 1,
                         64'h7000, 1'b1, 8'hC0, 64'hCDEF_0000_0000_0000, 64'h0});
        vecs.push_back('{MEM_SD,  64'h7008, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0,
                         64'h7008, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0});
        vecs.push_back('{mem_op_enum'(4'd13), 64'h7010, 64'h0, 64'h5555_AAAA_1234_8000, 0, 0,
                         64'h7010, 1'b0, 8'h00, 64'h0, 64'h5555_AAAA_1234_8000});
`ifndef MEM_MISALIGN_TRAP_EN
        // Misaligned accesses fall back to the containing aligned unit.
        vecs.push_back('{MEM_LW,  64'h5002, 64'h0, 64'h0000_0001_8000_0000, 0, 0,
                         64'h5000, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{MEM_SW,  64'h5002, 64'h1234_5678, 64'h0, 0, 0,
                         64'h5000, 1'b1, 8'h0F, 64'h0000_0000_1234_5678, 64'h0});
        vecs.push_back('{MEM_SH,  64'h5003, 64'hBEEF, 64'h0, 0, 0,
                         64'h5000, 1'b1, 8'h0C, 64'h0000_0000_BEEF_0000, 64'h0});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            access($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].resp,
                   vecs[i].rdy, vecs[i].rsp, 1'b0, vecs[i].eaddr, vecs[i].ewe, vecs[i].emask,
                   vecs[i].ewdata, vecs[i].erdata);
        end

        // ---------------- randomized accesses vs memory model ----------------
        for (int k = 0; k < 8; k++) begin
            tmp = {$urandom, $urandom};
            busmem[61'h1000 + 61'(k)] = tmp;
            shadow[61'h1000 + 61'(k)] = tmp;
        end
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) op = mem_op_enum'(4'($urandom_range(11, 15)));
            else                           op = mem_op_enum'(4'($urandom_range(0, 10)));
            addr = 64'h8000 + 64'($urandom_range(0, 63));
`ifdef MEM_MISALIGN_TRAP_EN
            addr = addr - 64'(int'(addr[2:0]) % op_bytes(op));
`endif
            wd = {$urandom, $urandom};
            model_access($sformatf("rnd%0d", it), op, addr, wd,
                         $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // ---------------- back-to-back SD then LD ----------------
        model_access("b2b_sd", MEM_SD, 64'h4000, 64'hA5A5_0123_4567_89AB, 0, 0);
        model_access("b2b_ld", MEM_LD, 64'h4000, 64'h0, 0, 0);

        // ---------------- reset while in RESP ----------------
        @(negedge clk);
        req_valid = 1'b1; req_op = MEM_LD; req_addr = 64'h4000; req_wdata = '0;
        n = 0;
        do begin
            @(negedge clk); #1; n++;
        end while (!mem_req_valid && n < 16);
        check("rsta_reqv", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        check("rsta_pre_rdata", rdata, 64'hA5A5_0123_4567_89AB);
        rstn = 1'b0; req_valid = 1'b0;
        #1;
        check("rsta_done", done, 0);
        check("rsta_rdata", rdata, 0);
        check("rsta_reqv0", mem_req_valid, 0);
        check("rsta_we", mem_we, 0);
        check("rsta_addr", mem_addr, 0);
        check("rsta_wdata", mem_wdata, 0);
        check("rsta_mask", mem_wmask, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_resp_data = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            #1;
            check("rsta_stale_done", done, 0);
            check("rsta_stale_rdata", rdata, 0);
            check("rsta_stale_reqv", mem_req_valid, 0);
        end
        access("recover", MEM_LB, 64'h1003, 64'h0, 64'h0000_0000_80FF_0000, 0, 0, 1'b0,
               64'h1000, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);

`ifdef MEM_MISALIGN_TRAP_EN
        // ---------------- misaligned trap ----------------
        @(negedge clk);
        req_valid = 1'b1; req_op = MEM_LW; req_addr = 64'h5002; req_wdata = '0;
        #1;
        check("mis_c0_stall", stall, 1);
        @(negedge clk); #1;
        check("mis_done", done, 1);
        check("mis_err", misalign_err, 1);
        check("mis_reqv", mem_req_valid, 0);
        check("mis_rdata", rdata, 0);
        req_valid = 1'b0;
        @(negedge clk); #1;
        check("mis_done_clr", done, 0);
        check("mis_err_clr", misalign_err, 0);
        check("mis_reqv2", mem_req_valid, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store engine between the core's MEM stage and the data-memory bus; produces the MEM operand consumed by the writeback select (WB_SEL_MEM).
- Captures one load/store request, drives a valid/ready bus request with byte mask and lane-shifted write data, and waits for the bus response.
- Returns aligned, sign- or zero-extended load data and stalls the core until the access completes.

Parameters:
- XLEN, 64, data and address width; only 64 is supported.
- MASK_W, XLEN/8, byte-mask width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  1  core requests an access; held stable until done.
- req_op  in  mem_op_enum (4)  access type: MEM_LB, MEM_LH, MEM_LW, MEM_LD, MEM_LBU, MEM_LHU, MEM_LWU, MEM_SB, MEM_SH, MEM_SW, MEM_SD.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- stall  out  1  core must hold the MEM stage.
- done  out  1  one-cycle completion pulse.
- rdata  out  XLEN  extended load data; valid while done=1; 0 for stores.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts the request.
- mem_we  out  1  1 = store.
- mem_addr  out  XLEN  doubleword-aligned address (low 3 bits zero).
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wmask  out  MASK_W  byte enables.
- mem_resp_valid  in  1  read data or write acknowledge.
- mem_resp_data  in  XLEN  raw 64-bit read doubleword.

Behaviour:
- Reset: asynchronous, rstn=0. State goes to IDLE. All outputs are 0, including the latched request registers and rdata.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - req_valid=1 latches op, addr and wdata, then moves to REQ.
  - stall = req_valid.
- REQ:
  - mem_req_valid=1, with outputs taken from the latched copies.
  - mem_req_ready=1 moves to RESP; otherwise hold all bus outputs stable.
- RESP:
  - mem_resp_valid=1 latches the extended data (loads) and moves to DONE.
  - A response arriving in the same cycle as acceptance is not possible; the bus answers no earlier than the cycle after ready.
- DONE:
  - done=1, stall=0, rdata valid; returns to IDLE the next cycle.
  - A new req_valid is sampled only in IDLE, so back-to-back accesses have a one-cycle gap.
- stall = req_valid in IDLE/REQ/RESP; 0 in DONE.
- Minimum latency: request seen in cycle 0, mem_req_valid in cycle 1, response in cycle 2, done in cycle 3.
- Store mask: SB = 8'h01<<a[2:0]; SH = 8'h03<<{a[2:1],1'b0}; SW = 8'h0F<<{a[2],2'b0}; SD = 8'hFF.
- Store data: mem_wdata = req_wdata << (a[2:0]*8).
- Load data: raw = mem_resp_data >> (a[2:0]*8), truncated to the access size. Signed ops sign-extend from the top bit; U ops zero-extend; LD passes through.
- Misaligned accesses (no feature): the offending low bits are ignored for mask and shift; the access is performed on the naturally aligned containing unit.
- mem_resp_valid outside RESP is ignored.
- Reset mid-access abandons the transaction. A late response arriving after reset is ignored.
- req_op values not in the enum are treated as MEM_LD.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misalign_err (1 bit).
  - A misaligned access (H with a[0]=1; W with a[1:0]≠0; D with a[2:0]≠0) goes IDLE→DONE directly, with no bus request.
  - done=1, misalign_err=1, rdata=0.
  - misalign_err=0 at all other times and in reset.
- Undefined: no port; behaviour is the aligned-containment rule above.

Decomposition:
- Shared package:
  - mem_op_enum, placed alongside wb_sel_op_enum and the ALU select enums.
  - mem_state_enum {MEM_IDLE, MEM_REQ, MEM_RESP, MEM_DONE}.
  - Constant MEM_MASK_W = 8.
- One combinational sub-module, mem_data_align, computes wmask, wdata shift, load extraction/extension and the misalign flag.
- The top level holds the FSM and the latched request.

Test Plan:
- LB at addr 0x1003 with resp_data 0x0000_0000_80FF_0000 and ready/resp each after 1 cycle → mem_addr 0x1000, mask 0x00, done at cycle 3, rdata 0xFFFF_FFFF_FFFF_FF80 (byte 3 = 0x80 sign-extended).
- LHU at addr 0x2006 with resp_data 0xBEEF_0000_0000_0000 → rdata 0x0000_0000_0000_BEEF; stall=1 for cycles 0–2, 0 at done.
- SW at addr 0x3004 with wdata 0x1234_5678 → mem_we=1, mem_wmask 0xF0, mem_wdata 0x1234_5678_0000_0000; mem_req_ready held low 4 cycles → bus outputs stable throughout; done once resp_valid arrives.
- SD at 0x4000, then LD at 0x4000 back-to-back → one idle cycle between the done pulse and the second mem_req_valid; rdata = stored value from the bench memory model.
- rstn pulled low while in RESP, with a stale mem_resp_valid 1 cycle after release → outputs 0 immediately, state IDLE, no done pulse, stale response ignored.
- With MEM_MISALIGN_TRAP_EN, LW at 0x5002 → no mem_req_valid, done and misalign_err=1 in cycle 1, rdata 0; without the macro → mask 0x0F, access proceeds.
